// File: rtl/flash_obi_arb_pkg.sv
// Shared types and constants for the two-master OBI flash arbiter.
package flash_obi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HIT  = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  localparam int HW_ACCESS_BIT = 23;
  // Word address of the hardware window: addr[22:2].
  localparam int BUF_AW        = 21;

  function automatic owner_t other_master(owner_t o);
    return (o == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/flash_obi_hitbuf.sv
// One-word read buffer for hardware-window flash reads: compare, fill and invalidate.
module flash_obi_hitbuf
  import flash_obi_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lookup_hw_rd,
  input  logic [BUF_AW-1:0] lookup_addr,
  output logic              hit,
  output logic [31:0]       buf_data,
  input  logic              fill,
  input  logic [BUF_AW-1:0] fill_addr,
  input  logic [31:0]       fill_data,
  input  logic              inval
);

  logic              buf_vld_q;
  logic [BUF_AW-1:0] buf_addr_q;
  logic [31:0]       buf_data_q;

  // A write may start program/erase, so invalidation beats a coincident fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else if (inval) begin
      buf_vld_q  <= 1'b0;
    end else if (fill) begin
      buf_vld_q  <= 1'b1;
      buf_addr_q <= fill_addr;
      buf_data_q <= fill_data;
    end
  end

  assign hit      = lookup_hw_rd && buf_vld_q && (lookup_addr == buf_addr_q);
  assign buf_data = buf_data_q;

endmodule

// File: rtl/flash_obi_arb.sv
// Round-robin arbiter sharing the flash OBI slave between fetch (m0) and data (m1) masters.
module flash_obi_arb
  import flash_obi_arb_pkg::*;
#(
  parameter bit HIT_BUF_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i
);

  state_t            state_q, state_d;
  owner_t            prio_q, prio_d, owner_q, owner_d, winner;
  logic              is_hw_rd_q;
  logic [BUF_AW-1:0] addr_q;
  logic              latch_txn, win_gnt, arb_active;
  logic              win_we, win_hw_rd;
  logic [3:0]        win_be;
  logic [31:0]       win_addr, win_wdata;
  logic              rsp_valid, fill, inval, hit;
  logic [31:0]       rsp_data, buf_data;

  always_comb begin
    winner = M0;
    if (m0_req_i && m1_req_i) winner = prio_q;
    else if (m1_req_i)        winner = M1;
  end

  assign win_we     = (winner == M1) ? m1_we_i    : m0_we_i;
  assign win_be     = (winner == M1) ? m1_be_i    : m0_be_i;
  assign win_addr   = (winner == M1) ? m1_addr_i  : m0_addr_i;
  assign win_wdata  = (winner == M1) ? m1_wdata_i : m0_wdata_i;
  assign win_hw_rd  = !win_we && win_addr[HW_ACCESS_BIT];
  // Gating with rst_ni keeps every output quiet while reset is held.
  assign arb_active = rst_ni && (state_q == IDLE) && (m0_req_i || m1_req_i);

  generate
    if (HIT_BUF_EN) begin : g_hitbuf
      flash_obi_hitbuf u_hitbuf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lookup_hw_rd (win_hw_rd),
        .lookup_addr  (win_addr[HW_ACCESS_BIT-1:2]),
        .hit          (hit),
        .buf_data     (buf_data),
        .fill         (fill),
        .fill_addr    (addr_q),
        .fill_data    (s_rdata_i),
        .inval        (inval)
      );
    end else begin : g_no_hitbuf
      assign hit      = 1'b0;
      assign buf_data = '0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    latch_txn = 1'b0;
    win_gnt   = 1'b0;
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    fill      = 1'b0;
    inval     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_active) begin
          if (hit) begin
            win_gnt = 1'b1;
            state_d = HIT;
            owner_d = winner;
            prio_d  = other_master(winner);
          end else begin
            s_req_o   = 1'b1;
            s_we_o    = win_we;
            s_be_o    = win_be;
            s_addr_o  = win_addr;
            s_wdata_o = win_wdata;
            if (s_gnt_i) begin
              win_gnt   = 1'b1;
              state_d   = BUSY;
              owner_d   = winner;
              latch_txn = 1'b1;
              prio_d    = other_master(winner);
              inval     = win_we;
            end
          end
        end
      end
      BUSY: begin
        if (s_rvalid_i) begin
          rsp_valid = 1'b1;
          rsp_data  = s_rdata_i;
          fill      = is_hw_rd_q;
          state_d   = IDLE;
        end
      end
      HIT: begin
        rsp_valid = 1'b1;
        rsp_data  = buf_data;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      prio_q     <= M0;
      owner_q    <= M0;
      is_hw_rd_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      if (latch_txn) begin
        is_hw_rd_q <= win_hw_rd;
        addr_q     <= win_addr[HW_ACCESS_BIT-1:2];
      end
    end
  end

  assign m0_gnt_o    = win_gnt && (winner == M0);
  assign m1_gnt_o    = win_gnt && (winner == M1);
  assign m0_rvalid_o = rsp_valid && (owner_q == M0);
  assign m1_rvalid_o = rsp_valid && (owner_q == M1);
  assign m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;

endmodule

// File: tb/tb_flash_obi_arb.sv
// Directed bench for flash_obi_arb: miss, hit, invalidate, round-robin, sw read and reset abort.
module tb_flash_obi_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
  logic [3:0]  m0_be_i = 0, m1_be_i = 0;
  logic [31:0] m0_addr_i = 0, m0_wdata_i = 0, m1_addr_i = 0, m1_wdata_i = 0;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic        s_gnt_i = 0, s_rvalid_i = 0;
  logic [31:0] s_rdata_i = 0;

  int n_cmp = 0;
  int n_err = 0;

  flash_obi_arb #(.HIT_BUF_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic log_txn(input string who, input logic [31:0] addr, input logic [31:0] data);
    $display("txn %s addr=0x%08h data=0x%08h t=%0t", who, addr, data, $time);
  endtask

  initial begin
    // Reset state, with a request present to show outputs stay gated.
    #1;
    m0_req_i = 1; m0_addr_i = 32'h0080_0100; m0_be_i = 4'hF; s_gnt_i = 1;
    #2;
    check("rst_m0_gnt", {31'b0, m0_gnt_o}, 0);
    check("rst_m1_gnt", {31'b0, m1_gnt_o}, 0);
    check("rst_s_req", {31'b0, s_req_o}, 0);
    check("rst_s_addr", s_addr_o, 0);
    check("rst_m0_rvalid", {31'b0, m0_rvalid_o}, 0);
    check("rst_m0_rdata", m0_rdata_o, 0);
    m0_req_i = 0; s_gnt_i = 0;
    #9 rst_ni = 1;
    step();

    // Hardware read miss, response 20 cycles later.
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h0080_0100; s_gnt_i = 1;
    settle();
    check("t1_m0_gnt", {31'b0, m0_gnt_o}, 1);
    check("t1_m1_gnt", {31'b0, m1_gnt_o}, 0);
    check("t1_s_req", {31'b0, s_req_o}, 1);
    check("t1_s_addr", s_addr_o, 32'h0080_0100);
    step();
    m0_req_i = 0; s_gnt_i = 0;
    settle();
    check("t1_busy_s_req", {31'b0, s_req_o}, 0);
    check("t1_busy_rvalid", {31'b0, m0_rvalid_o}, 0);
    repeat (18) step();
    step();
    s_rvalid_i = 1; s_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("t1_m0_rvalid", {31'b0, m0_rvalid_o}, 1);
    check("t1_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    check("t1_m1_rvalid", {31'b0, m1_rvalid_o}, 0);
    check("t1_m1_rdata", m1_rdata_o, 0);
    log_txn("m0 rd miss", 32'h0080_0100, m0_rdata_o);
    step();
    s_rvalid_i = 0; s_rdata_i = 0;

    // Same read again: served from the buffer.
    m0_req_i = 1; m0_addr_i = 32'h0080_0100; s_gnt_i = 1;
    settle();
    check("t2_m0_gnt", {31'b0, m0_gnt_o}, 1);
    check("t2_s_req", {31'b0, s_req_o}, 0);
    check("t2_m0_rvalid_early", {31'b0, m0_rvalid_o}, 0);
    step();
    m0_req_i = 0;
    settle();
    check("t2_m0_rvalid", {31'b0, m0_rvalid_o}, 1);
    check("t2_m0_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    check("t2_hit_no_gnt", {31'b0, m0_gnt_o}, 0);
    log_txn("m0 rd hit", 32'h0080_0100, m0_rdata_o);
    step();

    // m1 control-register write invalidates the buffer.
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 0; m1_wdata_i = 32'h0000_00A5; m1_be_i = 4'hF;
    settle();
    check("t3_m1_gnt", {31'b0, m1_gnt_o}, 1);
    check("t3_s_we", {31'b0, s_we_o}, 1);
    check("t3_s_wdata", s_wdata_o, 32'h0000_00A5);
    step();
    m1_req_i = 0; m1_we_i = 0;
    step();
    s_rvalid_i = 1; s_rdata_i = 0;
    settle();
    check("t3_m1_rvalid", {31'b0, m1_rvalid_o}, 1);
    check("t3_m0_rvalid", {31'b0, m0_rvalid_o}, 0);
    log_txn("m1 wr", 32'h0, 32'h0000_00A5);
    step();
    s_rvalid_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h0080_0100;
    settle();
    check("t3_miss_s_req", {31'b0, s_req_o}, 1);
    check("t3_miss_m0_gnt", {31'b0, m0_gnt_o}, 1);
    step();
    m0_req_i = 0;
    step();
    s_rvalid_i = 1; s_rdata_i = 32'hCAFE_F00D;
    settle();
    check("t3_miss_rdata", m0_rdata_o, 32'hCAFE_F00D);
    log_txn("m0 rd after wr", 32'h0080_0100, m0_rdata_o);
    step();
    s_rvalid_i = 0;

    // Both masters requesting sw reads: pointer currently favours m1.
    m0_req_i = 1; m0_addr_i = 32'h0000_0010;
    m1_req_i = 1; m1_addr_i = 32'h0000_0014;
    for (int i = 0; i < 4; i++) begin
      logic exp_m1;
      exp_m1 = (i % 2 == 0);
      settle();
      check("t4_m0_gnt", {31'b0, m0_gnt_o}, {31'b0, ~exp_m1});
      check("t4_m1_gnt", {31'b0, m1_gnt_o}, {31'b0, exp_m1});
      check("t4_s_addr", s_addr_o, exp_m1 ? 32'h14 : 32'h10);
      step();
      step();
      s_rvalid_i = 1; s_rdata_i = 32'(i);
      settle();
      check("t4_m0_rvalid", {31'b0, m0_rvalid_o}, {31'b0, ~exp_m1});
      check("t4_m1_rvalid", {31'b0, m1_rvalid_o}, {31'b0, exp_m1});
      log_txn(exp_m1 ? "m1 rd rr" : "m0 rd rr", exp_m1 ? 32'h14 : 32'h10, s_rdata_i);
      step();
      s_rvalid_i = 0;
    end
    m0_req_i = 0; m1_req_i = 0;

    // m1 sw read with a stalled slave grant; must not fill the buffer.
    m1_req_i = 1; m1_addr_i = 32'h0000_0008; s_gnt_i = 0;
    settle();
    check("t5_stall_gnt", {31'b0, m1_gnt_o}, 0);
    check("t5_stall_s_req", {31'b0, s_req_o}, 1);
    step();
    settle();
    check("t5_stall2_s_req", {31'b0, s_req_o}, 1);
    step();
    s_gnt_i = 1;
    settle();
    check("t5_m1_gnt", {31'b0, m1_gnt_o}, 1);
    step();
    m1_req_i = 0;
    step();
    s_rvalid_i = 1; s_rdata_i = 32'h55AA_55AA;
    settle();
    check("t5_m1_rdata", m1_rdata_o, 32'h55AA_55AA);
    log_txn("m1 sw rd", 32'h8, m1_rdata_o);
    step();
    s_rvalid_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h0080_0008;
    settle();
    check("t5_hw_miss_s_req", {31'b0, s_req_o}, 1);
    check("t5_hw_miss_gnt", {31'b0, m0_gnt_o}, 1);
    step();
    m0_req_i = 0;
    m1_req_i = 1; m1_addr_i = 32'h0000_0020;
    settle();
    check("t5_busy_m1_gnt", {31'b0, m1_gnt_o}, 0);

    // Reset while BUSY: outputs drop immediately; state, buffer and pointer cleared.
    #1;
    rst_ni = 0; s_rvalid_i = 1; s_rdata_i = 32'h0000_0077;
    m0_req_i = 1; m0_addr_i = 32'h0080_0100;
    #1;
    check("t6_rst_m0_rvalid", {31'b0, m0_rvalid_o}, 0);
    check("t6_rst_m0_rdata", m0_rdata_o, 0);
    check("t6_rst_s_req", {31'b0, s_req_o}, 0);
    check("t6_rst_m0_gnt", {31'b0, m0_gnt_o}, 0);
    check("t6_rst_m1_gnt", {31'b0, m1_gnt_o}, 0);
    check("t6_rst_s_addr", s_addr_o, 0);
    step();
    rst_ni = 1; s_rvalid_i = 0; s_rdata_i = 0;
    settle();
    check("t6_prio_m0_gnt", {31'b0, m0_gnt_o}, 1);
    check("t6_prio_m1_gnt", {31'b0, m1_gnt_o}, 0);
    check("t6_buf_miss_s_req", {31'b0, s_req_o}, 1);
    check("t6_s_addr", s_addr_o, 32'h0080_0100);
    step();
    m0_req_i = 0; m1_req_i = 0;
    step();
    s_rvalid_i = 1; s_rdata_i = 32'h1234_5678;
    settle();
    check("t6_m0_rdata", m0_rdata_o, 32'h1234_5678);
    log_txn("m0 rd post-rst", 32'h0080_0100, m0_rdata_o);
    step();
    s_rvalid_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
